// File: rtl/prog_pkg.sv
// Shared definitions for the program-chain loader: FSM state encoding,
// CRC-8 constants and small helper functions.
package prog_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Number of whole or partial bytes needed to cover a chain of 'bits' bits.
  function automatic int unsigned bits_to_bytes(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

  // One MSB-first LFSR step of CRC-8 with the data bit entering at the top.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic bit_in);
    logic fb;
    fb = crc_in[7] ^ bit_in;
    return {crc_in[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/prog_byte_fifo.sv
// Small synchronous byte FIFO for the program loader.
// Flush and reset both empty it; push is ignored when full, pop when empty.
module prog_byte_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush takes priority over any push/pop in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/prog_loader.sv
// Host-side writer for the controller's serial program chain.
// Bytes arrive over valid/ready, are buffered in a small FIFO and shifted
// LSB-first onto prog_data while prog_enable holds the controller in its
// program state. An underflow mid-load is fatal (sticky error).
// Optional CRC-8 check of the shifted stream: define PROG_LOADER_CRC_EN.
module prog_loader
  import prog_pkg::*;
#(
  parameter int unsigned PROG_BITS  = 256,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           byte_valid,
  input  logic [7:0]                     byte_data,
  output logic                           byte_ready,
  output logic                           prog_enable,
  output logic                           prog_data,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
`ifdef PROG_LOADER_CRC_EN
  output logic [7:0]                     crc,
`endif
  output logic [$clog2(PROG_BITS+1)-1:0] bit_count
);

  localparam int unsigned CW       = $clog2(PROG_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(PROG_BITS - 1);

  state_e          state_q, state_d;
  logic [7:0]      shifter_q, shifter_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            pe_q, pd_q, busy_q, done_q, err_q;

  logic            fifo_flush;
  logic            fifo_push;
  logic            fifo_pop;
  logic [7:0]      fifo_data;
  logic            fifo_full;
  logic            fifo_empty;

`ifdef PROG_LOADER_CRC_EN
  logic [7:0]      crc_q, crc_d;
  assign crc = crc_q;
`endif

  // Ready does not look ahead at a same-cycle pop: a full FIFO refuses the byte.
  assign byte_ready = !fifo_full && (state_q inside {S_PRIME, S_SHIFT, S_CHECK});
  assign fifo_push  = byte_valid && byte_ready;

  prog_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (byte_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state and datapath: bit shifting, byte refills and load completion.
  always_comb begin
    state_d    = state_q;
    shifter_d  = shifter_q;
    bit_idx_d  = bit_idx_q;
    bit_cnt_d  = bit_cnt_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
`ifdef PROG_LOADER_CRC_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_PRIME;
          bit_cnt_d  = '0;
          fifo_flush = 1'b1;
`ifdef PROG_LOADER_CRC_EN
          crc_d      = CRC8_INIT;
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_PRIME: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shifter_d = fifo_data;
          bit_idx_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shifter_d = shifter_q >> 1;
        bit_idx_d = bit_idx_q + 3'd1;
        bit_cnt_d = bit_cnt_q + CW'(1);
`ifdef PROG_LOADER_CRC_EN
        crc_d     = crc8_step(crc_q, shifter_q[0]);
`endif
        // Completion is tested before the byte boundary so that a final
        // partial or exact byte never asks for a refill.
        if (bit_cnt_q == LAST_IDX) begin
`ifdef PROG_LOADER_CRC_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else if (bit_idx_q == 3'd7) begin
          if (fifo_empty) begin
            state_d = S_ERROR;
          end else begin
            fifo_pop  = 1'b1;
            shifter_d = fifo_data;
          end
        end
      end
`ifdef PROG_LOADER_CRC_EN
      S_CHECK: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = (fifo_data == crc_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shifter_q <= '0;
      bit_idx_q <= '0;
      bit_cnt_q <= '0;
      pe_q      <= 1'b0;
      pd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PROG_LOADER_CRC_EN
      crc_q     <= CRC8_INIT;
`endif
    end else begin
      state_q   <= state_d;
      shifter_q <= shifter_d;
      bit_idx_q <= bit_idx_d;
      bit_cnt_q <= bit_cnt_d;
      pe_q      <= state_d inside {S_PRIME, S_SHIFT, S_CHECK, S_ERROR};
      pd_q      <= (state_d == S_SHIFT) && shifter_d[0];
      busy_q    <= state_d inside {S_PRIME, S_SHIFT, S_CHECK};
      done_q    <= (state_d == S_DONE);
      err_q     <= (state_d == S_ERROR);
`ifdef PROG_LOADER_CRC_EN
      crc_q     <= crc_d;
`endif
    end
  end

  assign prog_enable = pe_q;
  assign prog_data   = pd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign bit_count   = bit_cnt_q;

endmodule
